// File: rtl/pcie_reset_pkg.sv
// Shared types and helpers for the PCIe AXI-domain reset sequencer.
package pcie_reset_pkg;

  typedef enum logic [1:0] {RESET, HOLD, STAGE, RUN} rst_seq_state_t;

  localparam int RESTART_CNT_W = 8;
  localparam int MAX_DOMAINS   = 8;

  // Low n bits set, upper bits clear; callers truncate to their domain count.
  function automatic logic [MAX_DOMAINS-1:0] thermo(input int n);
    logic [MAX_DOMAINS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DOMAINS; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pcie_reset_sequencer_bit_sync.sv
// Multi-flop single-bit synchroniser with synchronous active-high clear.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pcie_reset_sequencer.sv
// Qualifies MMCM lock and PERST#, holds all domains, then releases active-low
// resets in index order; link-gated domains also track PCIe link-up.
module pcie_reset_sequencer
  import pcie_reset_pkg::*;
#(
  parameter int                     NUM_DOMAINS = 3,
  parameter int                     HOLD_CYCLES = 16,
  parameter int                     STAGE_GAP   = 4,
  parameter logic [MAX_DOMAINS-1:0] LINK_GATE   = 8'b0000_0100,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     mmcm_lock,
  input  logic                     perst_n,
  input  logic                     link_up,
  output logic [NUM_DOMAINS-1:0]   rst_out_n,
  output logic                     seq_done,
  output logic [RESTART_CNT_W-1:0] restart_cnt
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]          GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]          IDX_LAST  = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] GATE      = LINK_GATE[NUM_DOMAINS-1:0];

  rst_seq_state_t           state_q;
  logic [CW-1:0]            cnt_q;
  logic [IW-1:0]            idx_q;
  logic [NUM_DOMAINS-1:0]   rst_out_q;
  logic                     seq_done_q;
  logic [RESTART_CNT_W-1:0] restart_q;

  logic                     perst_sync;
  logic                     qualify;
  logic                     link_loss_d;
  logic [IW-1:0]            gate_idx_d;
  logic [NUM_DOMAINS-1:0]   gated_rel;
  logic [NUM_DOMAINS-1:0]   gate_sh;
  logic                     idx_link_ok;
  logic [NUM_DOMAINS-1:0]   rel_bit;
  logic [NUM_DOMAINS-1:0]   keep_mask;

  bit_sync #(.STAGES(SYNC_STAGES)) u_perst_sync (
    .clk_i (aclk),
    .rst_i (areset),
    .d_i   (perst_n),
    .q_o   (perst_sync)
  );

  assign qualify = mmcm_lock & perst_sync;

  // Only released, link-gated domains can trigger a link-loss fallback.
  assign gated_rel   = rst_out_q & GATE;
  assign link_loss_d = !link_up && (|gated_rel) &&
                       ((state_q == STAGE) || (state_q == RUN));

  always_comb begin
    gate_idx_d = '0;
    for (int j = NUM_DOMAINS - 1; j >= 0; j--)
      if (gated_rel[j]) gate_idx_d = IW'(j);
  end

  assign keep_mask   = NUM_DOMAINS'(thermo(int'(gate_idx_d)));
  assign gate_sh     = GATE >> idx_q;
  assign idx_link_ok = link_up | !gate_sh[0];
  assign rel_bit     = NUM_DOMAINS'(1) << idx_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= RESET;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '0;
      seq_done_q <= 1'b0;
      restart_q  <= '0;
    end else if (state_q != RESET && !qualify) begin
      state_q    <= RESET;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '0;
      seq_done_q <= 1'b0;
      if (restart_q != '1) restart_q <= restart_q + RESTART_CNT_W'(1);
    end else if (link_loss_d) begin
      // Drop the lowest gated domain and everything above it, then resume staging there.
      state_q    <= STAGE;
      cnt_q      <= '0;
      idx_q      <= gate_idx_d;
      rst_out_q  <= rst_out_q & keep_mask;
      seq_done_q <= 1'b0;
      if (restart_q != '1) restart_q <= restart_q + RESTART_CNT_W'(1);
    end else begin
      unique case (state_q)
        RESET: begin
          rst_out_q  <= '0;
          seq_done_q <= 1'b0;
          if (qualify) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (cnt_q != HOLD_LAST) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (link_up || !GATE[0]) begin
            rst_out_q <= NUM_DOMAINS'(1);
            cnt_q     <= '0;
            idx_q     <= IW'(1);
            if (NUM_DOMAINS == 1) begin
              state_q    <= RUN;
              seq_done_q <= 1'b1;
            end else begin
              state_q <= STAGE;
            end
          end
        end
        STAGE: begin
          if (cnt_q != GAP_LAST) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (idx_link_ok) begin
            rst_out_q <= rst_out_q | rel_bit;
            cnt_q     <= '0;
            idx_q     <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_q    <= RUN;
              seq_done_q <= 1'b1;
            end
          end
        end
        RUN: ;
        default: state_q <= RESET;
      endcase
    end
  end

  assign rst_out_n   = rst_out_q;
  assign seq_done    = seq_done_q;
  assign restart_cnt = restart_q;

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// Directed bench: default 3-domain sequencer plus a single-domain, 1-cycle-hold variant.
module tb_pcie_reset_sequencer;

  logic       aclk = 1'b0;
  logic       areset;
  logic       lock_a, perst_a, link_a;
  logic [2:0] rst_a;
  logic       done_a;
  logic [7:0] rcnt_a;
  logic       lock_b, perst_b, link_b;
  logic [0:0] rst_b;
  logic       done_b;
  logic [7:0] rcnt_b;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  pcie_reset_sequencer u_dut_a (
    .aclk(aclk), .areset(areset), .mmcm_lock(lock_a), .perst_n(perst_a),
    .link_up(link_a), .rst_out_n(rst_a), .seq_done(done_a), .restart_cnt(rcnt_a)
  );

  pcie_reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .LINK_GATE(8'h00), .SYNC_STAGES(2)
  ) u_dut_b (
    .aclk(aclk), .areset(areset), .mmcm_lock(lock_b), .perst_n(perst_b),
    .link_up(link_b), .rst_out_n(rst_b), .seq_done(done_b), .restart_cnt(rcnt_b)
  );

  // Thermometer shape and single-rise rule, sampled away from the active edge.
  logic [2:0] prev_a = 3'b000;
  always @(negedge aclk) begin
    assert (((rst_a + 3'd1) & rst_a) == 3'd0) else begin
      fails++;
      $display("FAIL thermo_a got %b", rst_a);
    end
    assert ($countones(rst_a & ~prev_a) <= 1) else begin
      fails++;
      $display("FAIL single_rise_a got %b prev %b", rst_a, prev_a);
    end
    prev_a = rst_a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic       lock;
    logic       perst;
    logic       link;
    int         n;
    logic [2:0] rst;
    logic       done;
    logic [7:0] rcnt;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  initial begin
    // Edge counts are measured from the edge that first samples the new inputs.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 18, 3'b000, 1'b0, 8'd0};  // perst rise, not yet released
    tbl[1]  = '{1'b1, 1'b1, 1'b1,  1, 3'b001, 1'b0, 8'd0};  // [0] 18 edges after perst seen
    tbl[2]  = '{1'b1, 1'b1, 1'b1,  3, 3'b001, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1,  1, 3'b011, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1,  4, 3'b111, 1'b1, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0,  1, 3'b011, 1'b0, 8'd1};  // 1-cycle link drop in RUN
    tbl[6]  = '{1'b1, 1'b1, 1'b1,  3, 3'b011, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1,  1, 3'b111, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1,  1, 3'b000, 1'b0, 8'd2};  // lock loss in RUN
    tbl[9]  = '{1'b0, 1'b1, 1'b1,  3, 3'b000, 1'b0, 8'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b1,  1, 3'b000, 1'b0, 8'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 15, 3'b000, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b1,  1, 3'b001, 1'b0, 8'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b1,  4, 3'b011, 1'b0, 8'd2};
    tbl[14] = '{1'b1, 1'b1, 1'b1,  4, 3'b111, 1'b1, 8'd2};
    tbl[15] = '{1'b0, 1'b1, 1'b1,  1, 3'b000, 1'b0, 8'd3};
    tbl[16] = '{1'b1, 1'b1, 1'b1,  5, 3'b000, 1'b0, 8'd3};
    tbl[17] = '{1'b0, 1'b1, 1'b1,  1, 3'b000, 1'b0, 8'd4};  // lock loss mid-HOLD
    tbl[18] = '{1'b1, 1'b1, 1'b1, 16, 3'b000, 1'b0, 8'd4};
    tbl[19] = '{1'b1, 1'b1, 1'b1,  1, 3'b001, 1'b0, 8'd4};
    tbl[20] = '{1'b1, 1'b1, 1'b1,  8, 3'b111, 1'b1, 8'd4};
    tbl[21] = '{1'b0, 1'b1, 1'b1,  1, 3'b000, 1'b0, 8'd5};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 17, 3'b001, 1'b0, 8'd5};  // link down while staging
    tbl[23] = '{1'b1, 1'b1, 1'b0,  4, 3'b011, 1'b0, 8'd5};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 10, 3'b011, 1'b0, 8'd5};
    tbl[25] = '{1'b1, 1'b1, 1'b1,  1, 3'b111, 1'b1, 8'd5};
    tbl[26] = '{1'b1, 1'b0, 1'b1,  2, 3'b111, 1'b1, 8'd5};  // perst through synchroniser
    tbl[27] = '{1'b1, 1'b0, 1'b1,  1, 3'b000, 1'b0, 8'd6};

    areset = 1'b1;
    lock_a = 1'b1; perst_a = 1'b0; link_a = 1'b1;
    lock_b = 1'b1; perst_b = 1'b0; link_b = 1'b0;
    tick(3);
    chk("reset rst_a",  32'(rst_a),  32'd0);
    chk("reset done_a", 32'(done_a), 32'd0);
    chk("reset rcnt_a", 32'(rcnt_a), 32'd0);
    chk("reset rst_b",  32'(rst_b),  32'd0);
    areset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      lock_a  = tbl[i].lock;
      perst_a = tbl[i].perst;
      link_a  = tbl[i].link;
      tick(tbl[i].n);
      chk($sformatf("v%0d rst", i),  32'(rst_a),  32'(tbl[i].rst));
      chk($sformatf("v%0d done", i), 32'(done_a), 32'(tbl[i].done));
      chk($sformatf("v%0d rcnt", i), 32'(rcnt_a), 32'(tbl[i].rcnt));
    end

    // areset from RUN clears everything, including the restart counter
    perst_a = 1'b1;
    tick(30);
    chk("pre_areset rst", 32'(rst_a), 32'b111);
    areset = 1'b1;
    tick(1);
    chk("areset rst",  32'(rst_a),  32'd0);
    chk("areset done", 32'(done_a), 32'd0);
    chk("areset rcnt", 32'(rcnt_a), 32'd0);
    areset = 1'b0;

    // forced restarts: one edge in HOLD, one edge of lock loss
    lock_a = 1'b0;
    tick(3);
    for (int k = 0; k < 300; k++) begin
      lock_a = 1'b1;
      tick(1);
      lock_a = 1'b0;
      tick(1);
      if (k == 99) chk("rcnt_100", 32'(rcnt_a), 32'd100);
    end
    chk("rcnt_sat", 32'(rcnt_a), 32'd255);

    // single-domain variant: release one edge after qualify is sampled
    perst_b = 1'b1;
    tick(3);
    chk("b hold rst",  32'(rst_b),  32'd0);
    chk("b hold done", 32'(done_b), 32'd0);
    tick(1);
    chk("b run rst",  32'(rst_b),  32'd1);
    chk("b run done", 32'(done_b), 32'd1);
    lock_b = 1'b0;
    tick(1);
    chk("b loss rst",  32'(rst_b),  32'd0);
    chk("b loss done", 32'(done_b), 32'd0);
    chk("b loss rcnt", 32'(rcnt_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
